inference_sequencer: RTL
========================

// Module: inference_sequencer
// PURPOSE
// - Drives the image-memory address seen by Memory_Reader and paces the combinational neural_net.
// - On start, walks NUM_IMAGES images laid out IN_WIDTH words apart and waits SETTLE_CYCLES per image.
// - Captures each 32-bit net output, scores it against a label word and emits it over a valid/ready handshake.
// - Keeps a running count of correct predictions; sits between the top-level board control and the net datapath.
// PARAMETERS
// - IN_WIDTH       784  words per image; address stride.
// - NUM_IMAGES     16   images per run (>=1).
// - SETTLE_CYCLES  4    cycles between addr change and output capture (>=1); covers mem read + net settle.
// - BASE_ADDR      0    word address of image 0.
// PORTS
// - clk         in   1   system clock, all logic on rising edge.
// - rst         in   1   synchronous, active-high reset.
// - start       in   1   1-cycle pulse; begins a run when IDLE or DONE, ignored otherwise.
// - img_addr    out  32  word address into Memory_Reader = BASE_ADDR + idx*IN_WIDTH.
// - net_out     in   32  neural_net output word (outs[0]); predicted class.
// - lbl_addr    out  32  label-ROM address = idx.
// - lbl_data    in   32  expected class for image idx (combinational ROM).
// - res_valid   out  1   result word valid.
// - res_ready   in   1   consumer accepts result when res_valid & res_ready.
// - res_pred    out  32  captured prediction.
// - res_idx     out  16  image index of the result.
// - res_hit     out  1   res_pred == label.
// - busy        out  1   high in any state other than IDLE/DONE.
// - done        out  1   high in DONE until next start.
// - hit_count   out  16  correct predictions in current/last run.
// BEHAVIOUR
// - Reset: state=IDLE, idx=0, img_addr=BASE_ADDR, lbl_addr=0, res_valid=0, res_pred=0, res_idx=0, res_hit=0,
//   busy=0, done=0, hit_count=0, settle counter=0. Reset mid-run aborts immediately; no result emitted.
// - FSM IDLE -> (start) LOAD -> SETTLE -> CAPTURE -> EMIT -> LOAD (next idx) | DONE (last idx).
// - start in IDLE/DONE: idx<=0, hit_count<=0, done<=0, go LOAD.
// - LOAD (1 cycle): img_addr <= BASE_ADDR + idx*IN_WIDTH (registered; 32-bit, multiply by constant,
//   wraps mod 2^32), lbl_addr <= idx, settle counter <= SETTLE_CYCLES-1.
// - SETTLE: counter decrements each cycle; leaves when counter==0 -> exactly SETTLE_CYCLES cycles in SETTLE.
// - CAPTURE (1 cycle): res_pred<=net_out, res_hit<=(net_out==lbl_data), res_idx<=idx;
//   hit_count += hit (saturates at 16'hFFFF); res_valid<=1.
// - EMIT: hold res_* and res_valid stable until res_valid&res_ready; on that edge res_valid<=0 and
//   idx<=idx+1 -> LOAD, or if idx==NUM_IMAGES-1 -> DONE (idx held). Ready already high when entering
//   EMIT completes in that first EMIT cycle (no combinational valid->ready path required of consumer).
// - Latency: start to first res_valid = 1 (LOAD) + SETTLE_CYCLES + 1 (CAPTURE) = SETTLE_CYCLES+2 cycles
//   after the start edge; per-image period SETTLE_CYCLES+3 with ready tied high.
// - img_addr stays constant from LOAD through EMIT; net_out sampled only in CAPTURE.
// - DONE: done=1, busy=0, img_addr/hit_count hold; start re-arms (same as IDLE). start during busy ignored.
// - start and rst same cycle: rst wins.
// STRUCTURE
// - Package nn_ctrl_pkg: typedef enum logic [2:0] {S_IDLE,S_LOAD,S_SETTLE,S_CAPTURE,S_EMIT,S_DONE}
//   seq_state_t; localparams ADDR_W=32, IDX_W=16; struct res_t {pred, idx, hit}.
// - One sub-module natural: settle_timer (load value, dec, zero flag) reused for other pacing.
// - Everything else single always_ff FSM + datapath registers; no combinational outputs except busy/done
//   decoded from state.
// TESTING
// - Reset then start, NUM_IMAGES=3, IN_WIDTH=784, ready=1 -> img_addr 0,784,1568; res_idx 0,1,2; done
//   asserted after third handshake; first res_valid exactly SETTLE_CYCLES+2 cycles after start.
// - Backpressure: ready=0 for 10 cycles in EMIT -> res_* and img_addr stable, idx unchanged; ready=1
//   -> single handshake, next LOAD.
// - Scoring: labels {3,7,1}, net_out model returns {3,2,1} -> res_hit 1,0,1; hit_count=2 at done.
// - start pulses during SETTLE/EMIT -> ignored, sequence unperturbed; start in DONE -> hit_count clears,
//   img_addr returns to BASE_ADDR.
// - rst asserted in SETTLE of image 1 -> next cycle all outputs at reset values, no res_valid; fresh start
//   runs from idx 0.
// - BASE_ADDR=32'hFFFF_FF00, IN_WIDTH=784 -> img_addr wraps mod 2^32 (image 1 at 32'h0000_0210).

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the inference sequencer.
//   seq_state_t : sequencer FSM encoding
//   res_t       : one scored result (prediction, image index, hit flag)
//   sat_inc     : saturating increment used by the hit counter
package nn_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [31:0]      pred;
    logic [IDX_W-1:0] idx;
    logic             hit;
  } res_t;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == {IDX_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/inference_sequencer_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag, used to pace
// fixed wait intervals.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : count <= load_val (has priority over dec)
//   load_val  : reload value
//   dec       : decrement, stopping at zero
//   cnt, zero : current count and (cnt == 0)
module settle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: walks NUM_IMAGES images through the memory reader /
// combinational net, captures and scores each prediction and hands it out on
// a valid/ready port while counting correct predictions.
//   clk, rst            : clock, synchronous active-high reset
//   start               : 1-cycle pulse, starts a run from IDLE or DONE
//   img_addr            : image word address, BASE_ADDR + idx*IN_WIDTH
//   net_out             : net prediction, sampled in CAPTURE only
//   lbl_addr / lbl_data : label ROM address (= idx) and returned label
//   res_valid/res_ready : result handshake
//   res_pred/idx/hit    : captured prediction, its image index, hit flag
//   busy, done          : run in progress / run finished
//   hit_count           : saturating count of hits in the current/last run
module inference_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 784,
  parameter int unsigned NUM_IMAGES    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [31:0]       net_out,
  output logic [31:0]       lbl_addr,
  input  logic [31:0]       lbl_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_pred,
  output logic [IDX_W-1:0]  res_idx,
  output logic              res_hit,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  hit_count
);

  localparam int TMR_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMAGES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);

  seq_state_t       state, nstate;
  logic [IDX_W-1:0] idx;
  res_t             res;
  logic             hit_now;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_cnt;

  // Loaded in LOAD with SETTLE_CYCLES-1, so SETTLE lasts exactly
  // SETTLE_CYCLES cycles before the zero flag releases it.
  settle_timer #(.W(TMR_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_LOAD),
    .load_val (SETTLE_LD),
    .dec      (state == S_SETTLE),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  assign hit_now = (net_out == lbl_data);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_DONE: if (start) nstate = S_LOAD;
      S_LOAD:         nstate = S_SETTLE;
      S_SETTLE:       if (tmr_zero) nstate = S_CAPTURE;
      S_CAPTURE:      nstate = S_EMIT;
      S_EMIT:         if (res_ready) nstate = (idx == LAST_IDX) ? S_DONE : S_LOAD;
      default:        nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      img_addr  <= BASE_ADDR;
      lbl_addr  <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      hit_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx       <= '0;
            hit_count <= '0;
          end
        end
        S_LOAD: begin
          // Constant multiply; the sum wraps mod 2^32 by width.
          img_addr <= BASE_ADDR + ADDR_W'(idx) * ADDR_W'(IN_WIDTH);
          lbl_addr <= 32'(idx);
        end
        S_CAPTURE: begin
          res.pred  <= net_out;
          res.idx   <= idx;
          res.hit   <= hit_now;
          res_valid <= 1'b1;
          if (hit_now) hit_count <= sat_inc(hit_count);
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_pred = res.pred;
  assign res_idx  = res.idx;
  assign res_hit  = res.hit;
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);

endmodule
